// File: rtl/serial_word_collector_pkg.sv
// Shared types and constants for the serial word collector.
// Frame FSM states and width helpers.
package serial_word_collector_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_collector_if.sv
// Stream-side and word-side signals of the serial word collector.
// The slave modport is the collector; the master modport is its environment.
interface serial_word_collector_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             bit_in;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             frame_abort;
  logic             overrun;
  logic             clr_overrun;

  modport slave (
    input  start,
    input  bit_in,
    input  word_ready,
    input  clr_overrun,
    output word_out,
    output word_valid,
    output busy,
    output frame_abort,
    output overrun
  );

  modport master (
    output start,
    output bit_in,
    output word_ready,
    output clr_overrun,
    input  word_out,
    input  word_valid,
    input  busy,
    input  frame_abort,
    input  overrun
  );

endinterface

// File: rtl/serial_word_collector.sv
// Rebuilds LSB-first serial words and offers them on a valid/ready port.
// Reports aborted partial frames and words lost to back-pressure.
module serial_word_collector
  import serial_word_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  serial_word_collector_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_complete;
  logic             w_abort;
  logic             w_take;
  logic             w_drop;

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_abort;
  logic             r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // New bits enter at the MSB so the first bit ends up in bit 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    w_word      = {bus.bit_in, r_acc[WIDTH-1:1]};
    w_last      = (r_cnt == CW'(WIDTH - 1));
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_complete  = 1'b1;
          w_acc_nxt   = w_word;
          w_cnt_nxt   = '0;
          w_state_nxt = bus.start ? SHIFT : IDLE;
        end else if (bus.start) begin
          w_abort   = 1'b1;
          w_cnt_nxt = '0;
          w_acc_nxt = '0;
        end else begin
          w_acc_nxt = w_word;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_take = w_complete && (!r_valid || bus.word_ready);
  assign w_drop = w_complete && r_valid && !bus.word_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_abort   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (w_take) begin
        r_word  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && bus.word_ready) begin
        r_valid <= 1'b0;
      end
      // A fresh drop outranks a clear on the same edge.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.word_out    = r_word;
  assign bus.word_valid  = r_valid;
  assign bus.busy        = (r_state == SHIFT);
  assign bus.frame_abort = r_abort;
  assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench for serial_word_collector (WIDTH=16).
// Tasks drive frames; a negedge monitor pops expected words on accept.
module tb_serial_word_collector;

  localparam int W = 16;

  logic clk;
  logic rst;

  serial_word_collector_if #(.WIDTH(W)) bus ();

  serial_word_collector #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  logic [W-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h expected none", bus.word_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (bus.word_out !== e) begin
          errors++;
          $display("FAIL sb_word got %h expected %h", bus.word_out, e);
        end
      end
    end
    if (bus.frame_abort === 1'b1) abort_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic bits(input logic [W-1:0] w, input int lo, input int hi,
                      input bit chain);
    for (int k = lo; k <= hi; k++) begin
      bus.bit_in = w[k];
      bus.start  = chain && (k == W - 1);
      cyc();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({bus.word_valid, bus.busy, bus.frame_abort, bus.overrun} !== 4'b0 ||
        bus.word_out !== '0) begin
      errors++;
      $display("FAIL reset_state got v%b b%b a%b o%b w%h expected zeros",
               bus.word_valid, bus.busy, bus.frame_abort, bus.overrun,
               bus.word_out);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    bus.word_ready = 1'b1;
    exp_q.push_back(16'h00A3);
    start_frame();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b expected 1", bus.busy);
    end
    bits(16'h00A3, 0, 14, 0);
    checks++;
    if (bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early got %b expected 0", bus.word_valid);
    end
    bits(16'h00A3, 15, 15, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h00A3 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_word got v%b w%h b%b expected v1 w00a3 b0",
               bus.word_valid, bus.word_out, bus.busy);
    end
    cyc();
    checks++;
    if (bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_fall got %b expected 0", bus.word_valid);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = abort_cnt;
    bus.word_ready = 1'b1;
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h5A5A);
    start_frame();
    bits(16'hFFFF, 0, 15, 1);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'hFFFF ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got v%b w%h b%b expected v1 wffff b1",
               bus.word_valid, bus.word_out, bus.busy);
    end
    bits(16'h5A5A, 0, 15, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h5A5A) begin
      errors++;
      $display("FAIL b2b_second got v%b w%h expected v1 w5a5a",
               bus.word_valid, bus.word_out);
    end
    cyc();
    checks++;
    if (abort_cnt !== a0) begin
      errors++;
      $display("FAIL b2b_abort got %0d expected %0d", abort_cnt, a0);
    end
  endtask

  task automatic test_backpressure();
    bus.word_ready = 1'b0;
    exp_q.push_back(16'h1234);
    start_frame();
    bits(16'h1234, 0, 15, 1);
    bits(16'hBEEF, 0, 15, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h1234 ||
        bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got v%b w%h o%b expected v1 w1234 o1",
               bus.word_valid, bus.word_out, bus.overrun);
    end
    cyc();
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky got %b expected 1", bus.overrun);
    end
    bus.word_ready  = 1'b1;
    bus.clr_overrun = 1'b1;
    cyc();
    bus.clr_overrun = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear got v%b o%b expected v0 o0",
               bus.word_valid, bus.overrun);
    end
  endtask

  task automatic test_abort();
    int a0;
    a0 = abort_cnt;
    bus.word_ready = 1'b1;
    start_frame();
    bits(16'hFFFF, 0, 4, 0);
    exp_q.push_back(16'hC001);
    start_frame();
    checks++;
    if (bus.frame_abort !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse got a%b b%b expected a1 b1",
               bus.frame_abort, bus.busy);
    end
    bits(16'hC001, 0, 15, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'hC001) begin
      errors++;
      $display("FAIL abort_word got v%b w%h expected v1 wc001",
               bus.word_valid, bus.word_out);
    end
    cyc();
    checks++;
    if (abort_cnt !== a0 + 1) begin
      errors++;
      $display("FAIL abort_count got %0d expected %0d", abort_cnt, a0 + 1);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.word_ready = 1'b0;
    start_frame();
    bits(16'h3C3C, 0, 15, 0);
    start_frame();
    bits(16'hAAAA, 0, 7, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.word_valid, bus.busy, bus.frame_abort, bus.overrun} !== 4'b0 ||
        bus.word_out !== '0) begin
      errors++;
      $display("FAIL rst_async got v%b b%b a%b o%b w%h expected zeros",
               bus.word_valid, bus.busy, bus.frame_abort, bus.overrun,
               bus.word_out);
    end
    rst = 1'b0;
    cyc();
    checks++;
    if (bus.frame_abort !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_after got a%b b%b expected a0 b0",
               bus.frame_abort, bus.busy);
    end
    bus.word_ready = 1'b1;
    exp_q.push_back(16'h0F0F);
    start_frame();
    bits(16'h0F0F, 0, 15, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h0F0F) begin
      errors++;
      $display("FAIL rst_next got v%b w%h expected v1 w0f0f",
               bus.word_valid, bus.word_out);
    end
    cyc();
  endtask

  task automatic test_consume_complete();
    bus.word_ready = 1'b0;
    exp_q.push_back(16'h00A1);
    start_frame();
    bits(16'h00A1, 0, 15, 0);
    exp_q.push_back(16'h00B2);
    start_frame();
    bits(16'h00B2, 0, 14, 0);
    bus.word_ready = 1'b1;
    bits(16'h00B2, 15, 15, 0);
    checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 16'h00B2 ||
        bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_edge got v%b w%h o%b expected v1 w00b2 o0",
               bus.word_valid, bus.word_out, bus.overrun);
    end
    cyc();
    bus.word_ready = 1'b0;
    checks++;
    if (bus.word_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_fall got %b expected 0", bus.word_valid);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.bit_in      = 1'b0;
    bus.word_ready  = 1'b0;
    bus.clr_overrun = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid_frame();
    test_consume_complete();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

- Downstream stage of the right-shift parallel-to-serial register.
- Samples the LSB-first serial bit stream and rebuilds each WIDTH-bit word.
- Presents each finished word on a valid/ready output port.
- Flags words lost to back-pressure and frames cut short by a new frame start.

## Interface
- WIDTH, 16, word length in bits; must equal the upstream shift register width; legal range 2..64
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- start  in  1  frame marker; driven by the same signal that parallel-loads the upstream shift register
- bit_in  in  1  serial data, LSB first, from the upstream serial output
- word_out  out  WIDTH  assembled word; stable while word_valid=1
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out on any edge where word_valid && word_ready
- busy  out  1  a frame is being collected (state SHIFT)
- frame_abort  out  1  one-cycle pulse when a partial frame is discarded
- overrun  out  1  sticky; set when a completed word is dropped
- clr_overrun  in  1  synchronous clear of overrun

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - start=1 at an edge sets bit count cnt=0 and moves to SHIFT.
  - bit_in is ignored in IDLE.
- SHIFT:
  - On each edge, bit_in is written into the shift accumulator at the MSB end. The accumulator shifts right, so after WIDTH bits, bit 0 is the first bit received.
  - cnt increments on each edge.
  - When cnt reaches WIDTH-1, that edge captures the last bit. The block then returns to IDLE and issues a "complete" event.
- Complete event, when the output register is free or being consumed (word_valid=0, or word_ready=1 on the same edge):
  - word_out takes the new word.
  - word_valid=1.
- Complete event, when the output register is held (word_valid=1 && word_ready=0):
  - The new word is dropped.
  - overrun is set.
  - word_out and word_valid are unchanged.
- start=1 while in SHIFT, at an edge that is not the final-bit edge:
  - The partial word is discarded.
  - frame_abort pulses for one cycle.
  - cnt is reset to 0 and the state stays SHIFT (restart).
- start=1 on the final-bit edge:
  - The complete event happens normally.
  - The block goes to SHIFT with cnt=0, so frames can run back to back with no gap.
- Consume: word_valid && word_ready at an edge clears word_valid. The exception is an accepted complete event on the same edge, where word_valid stays 1 and word_out takes the new word.
- overrun:
  - Cleared only by rst or by clr_overrun=1.
  - If clr_overrun and a new overrun occur on the same edge, the set wins.

## Timing
- Reset values: state=IDLE, cnt=0, accumulator=0, word_out=0, word_valid=0, busy=0, frame_abort=0, overrun=0.
- rst asserted mid-frame abandons the frame immediately. No frame_abort pulse is produced.
- Frame timing, with start sampled high at edge E:
  - bit k is sampled at edge E+1+k.
  - The last bit is sampled at edge E+WIDTH.
  - word_valid rises after edge E+WIDTH.
  - Latency from start to valid is WIDTH+1 edges (WIDTH=16: 17).
- busy=1 for the cycles following edges E through E+WIDTH-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Sustained rate is one word per WIDTH cycles, with start re-asserted on each final-bit edge.

## Structure
- Shared package holds:
  - The state enum (IDLE, SHIFT).
  - The default width constant, 16.
  - The counter width, clog2(WIDTH).
- Single module. The output holding register and its handshake logic are small enough to stay inline; no sub-module.

## Test plan
- Single word: load 16'h00A3 upstream with start=1 for one cycle, then hold word_ready=1 -> word_valid rises 17 edges after start with word_out=16'h00A3, then falls on the next edge.
- Back-to-back: words 16'hFFFF then 16'h5A5A, with start on the final-bit edge of the first -> both delivered in order, 16 cycles apart, frame_abort never pulses.
- Back-pressure: word_ready=0, two complete frames (16'h1234, 16'hBEEF) -> word_out stays 16'h1234, overrun=1. Then word_ready=1 and clr_overrun=1 -> word_valid falls, overrun clears.
- Abort: start again 5 edges into a frame, then a full 16'hC001 frame -> one frame_abort pulse, then word_out=16'hC001 with no partial word delivered.
- Reset mid-frame: assert rst asynchronously (off a clock edge) at bit 8 -> all outputs return to reset values immediately. A following 16'h0F0F frame is delivered correctly.
- Consume and complete on the same edge: word_valid=1 with word_ready=1 on the final-bit edge of the next frame -> word_valid stays 1, word_out is the new word, overrun stays 0.
